// File: rtl/ram_port_ctrl.sv
// Generic first-word-fall-through FIFO with circular pointers wrapping at DEPTH.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: a push is taken only if not full or popped in the same cycle; pop needs head_vld.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             head_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]    LAST     = PW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign head_vld = (cnt != '0);
    assign full     = (cnt == FULL_CNT);
    assign do_pop   = head_vld & pop_rdy;
    assign do_push  = push_vld & (~full | do_pop);
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// Request/response front end for one latency-RAM port; in-order read returns via a FIFO.
// Latency: RAM signals are combinational from the request; read data surfaces READ_LATENCY+1 cycles after accept.
// Backpressure: writes always accepted; reads need a response credit and no pending write to the same address.
module ram_port_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 3,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 1,
    parameter int RSP_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    input  logic [DATA_WIDTH-1:0]    ram_dout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     busy,
    output logic                     hazard_stall
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(RSP_DEPTH);

    typedef struct packed {
        logic                     vld;
        logic [ADDRESS_WIDTH-1:0] addr;
    } wr_ent_t;

    logic                    accept;
    logic                    rd_accept;
    logic                    wr_accept;
    logic                    rd_hazard;
    logic                    credit_ok;
    logic                    rsp_push;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic [CW-1:0]           rd_inflight;
    logic [CW-1:0]           fifo_cnt;

    // Credit uses registered counts only, so a pop frees its slot one cycle later.
    assign credit_ok = (({1'b0, rd_inflight} + {1'b0, fifo_cnt}) < CREDIT_MAX);
    assign req_ready = rst_n & (req_we | (credit_ok & ~rd_hazard));
    assign accept    = req_valid & req_ready;
    assign rd_accept = accept & ~req_we;
    assign wr_accept = accept & req_we;

    assign ram_en   = accept;
    assign ram_we   = wr_accept;
    assign ram_addr = req_addr;
    assign ram_din  = req_wdata;

    assign hazard_stall = rst_n & req_valid & ~req_we & rd_hazard;
    assign rsp_push     = rd_pipe[READ_LATENCY-1];
    assign busy         = (rd_inflight != '0) | (fifo_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe     <= '0;
            rd_inflight <= '0;
        end else begin
            rd_pipe[0] <= rd_accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            case ({rd_accept, rsp_push})
                2'b10:   rd_inflight <= rd_inflight + 1'b1;
                2'b01:   rd_inflight <= rd_inflight - 1'b1;
                default: ;
            endcase
        end
    end

    // Writes still travelling through the RAM's write pipeline block reads to the same address.
    if (WRITE_LATENCY > 1) begin : g_wr_pipe
        localparam int WD = WRITE_LATENCY - 1;
        wr_ent_t wr_pipe [WD];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < WD; i++) begin
                    wr_pipe[i] <= '0;
                end
            end else begin
                wr_pipe[0].vld  <= wr_accept;
                wr_pipe[0].addr <= req_addr;
                for (int i = 1; i < WD; i++) begin
                    wr_pipe[i] <= wr_pipe[i-1];
                end
            end
        end

        always_comb begin
            rd_hazard = 1'b0;
            for (int i = 0; i < WD; i++) begin
                if (wr_pipe[i].vld && (wr_pipe[i].addr == req_addr)) begin
                    rd_hazard = 1'b1;
                end
            end
        end
    end else begin : g_no_wr_pipe
        assign rd_hazard = 1'b0;
    end

    fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH),
        .CNT_W (CW)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rsp_push),
        .push_dat (ram_dout),
        .head_vld (rsp_valid),
        .pop_rdy  (rsp_ready),
        .head_dat (rsp_rdata),
        .cnt      (fifo_cnt)
    );
endmodule
